// File: rtl/from_serial_if.sv
// Chunk-stream and reassembled-word bundle for the from_serial deserializer.
// The master is the upstream serializer; the slave is the deserializer itself.
interface from_serial_if #(
  parameter int BW      = 16,
  parameter int CYCS    = 4,
  parameter int VEC_LEN = 27
) ();
  localparam int W = BW / CYCS;

  logic                       vld_in;
  logic [VEC_LEN-1:0][W-1:0]  in;
  logic                       vld_out;
  logic [VEC_LEN-1:0][BW-1:0] out;
  logic                       busy;

  modport master (
    output vld_in,
    output in,
    input  vld_out,
    input  out,
    input  busy
  );

  modport slave (
    input  vld_in,
    input  in,
    output vld_out,
    output out,
    output busy
  );
endinterface

// File: rtl/from_serial.sv
// Rebuilds BW-bit words per lane from CYCS narrow chunks, LSB chunk first,
// and presents them with a one-cycle valid pulse while the next word assembles.
module from_serial #(
  parameter int BW      = 16,
  parameter int CYCS    = 4,
  parameter int VEC_LEN = 27
) (
  input  logic         clock,
  input  logic         reset_n,
  from_serial_if.slave bus
);
  localparam int W  = BW / CYCS;
  localparam int CW = $clog2(CYCS);
  localparam logic [CW-1:0] LAST = CW'(CYCS - 1);

  if (CYCS < 2) begin : g_bad_cycs
    $error("from_serial: CYCS must be at least 2");
  end
  if ((BW % CYCS) != 0) begin : g_bad_bw
    $error("from_serial: BW must be a multiple of CYCS");
  end

  logic [CW-1:0]                cnt_q, cnt_d;
  logic [VEC_LEN-1:0][BW-W-1:0] acc_q, acc_d;
  logic [VEC_LEN-1:0][BW-1:0]   out_q, out_d;
  logic                         vld_q, vld_d;

  logic                         last_chunk;
  logic [VEC_LEN-1:0][BW-W-1:0] acc_shift;
  logic [VEC_LEN-1:0][BW-1:0]   word_done;

  assign last_chunk = (cnt_q == LAST);

  // New chunk enters at the top so chunk 0 ends up in the low bits of the word.
  for (genvar gi = 0; gi < VEC_LEN; gi++) begin : g_lane
    if (CYCS == 2) begin : g_single
      assign acc_shift[gi] = bus.in[gi];
    end else begin : g_shift
      assign acc_shift[gi] = {bus.in[gi], acc_q[gi][BW-W-1:W]};
    end
    assign word_done[gi] = {bus.in[gi], acc_q[gi]};
  end

  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    out_d = out_q;
    vld_d = 1'b0;
    if (bus.vld_in) begin
      if (last_chunk) begin
        // acc is left as is: the next word overwrites every bit of it.
        out_d = word_done;
        cnt_d = '0;
        vld_d = 1'b1;
      end else begin
        acc_d = acc_shift;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      acc_q <= '0;
      out_q <= '0;
      vld_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      out_q <= out_d;
      vld_q <= vld_d;
    end
  end

  assign bus.vld_out = vld_q;
  assign bus.out     = out_q;
  assign bus.busy    = (cnt_q != '0);
endmodule

// File: tb/tb_from_serial.sv
// Scoreboard bench for from_serial: words are serialized by a simple model,
// expected words are queued at send time and matched by an independent monitor.
module tb_from_serial;
  localparam int BW      = 16;
  localparam int CYCS    = 4;
  localparam int VEC_LEN = 2;
  localparam int W       = BW / CYCS;

  typedef logic [VEC_LEN-1:0][BW-1:0] word_t;
  typedef logic [VEC_LEN-1:0][W-1:0]  chunk_t;

  logic clock;
  logic reset_n;

  from_serial_if #(.BW(BW), .CYCS(CYCS), .VEC_LEN(VEC_LEN)) bus ();

  from_serial #(.BW(BW), .CYCS(CYCS), .VEC_LEN(VEC_LEN)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int    checks = 0;
  int    errors = 0;
  int    exp_cnt = 0;      // chunks of the current word accepted so far
  int    words_sent = 0;
  int    pulses = 0;
  int    rst_count = 0;
  word_t exp_q[$];
  int    pulse_cyc[$];

  // Monitor: runs on the falling edge, away from the active edge.
  int    cyc = 0;
  int    seen_rst = 0;
  logic  prev_vld = 1'b0;
  word_t out_exp = '0;
  word_t popped;

  always @(negedge clock) begin
    cyc++;
    if (seen_rst != rst_count) begin
      seen_rst = rst_count;
      out_exp  = '0;
      prev_vld = 1'b0;
    end
    if (reset_n) begin
      checks++;
      if (bus.busy !== (exp_cnt != 0)) begin
        errors++;
        $display("FAIL busy cyc=%0d got=%b want=%b", cyc, bus.busy, (exp_cnt != 0));
      end
      if (bus.vld_out === 1'b1) begin
        checks++;
        if (prev_vld) begin
          errors++;
          $display("FAIL vld_consecutive cyc=%0d got=1 want=0", cyc);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse cyc=%0d got out=%h want no pulse", cyc, bus.out);
        end else begin
          popped = exp_q.pop_front();
          if (bus.out !== popped) begin
            errors++;
            $display("FAIL word cyc=%0d got=%h want=%h", cyc, bus.out, popped);
          end else begin
            $display("word %0d cyc=%0d out=%h", pulses, cyc, bus.out);
          end
          out_exp = popped;
          pulses++;
          pulse_cyc.push_back(cyc);
        end
      end else begin
        checks++;
        if (bus.vld_out !== 1'b0) begin
          errors++;
          $display("FAIL vld_out cyc=%0d got=%b want=0", cyc, bus.vld_out);
        end
        checks++;
        if (bus.out !== out_exp) begin
          errors++;
          $display("FAIL out_hold cyc=%0d got=%h want=%h", cyc, bus.out, out_exp);
        end
      end
      prev_vld = bus.vld_out;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic chunk_t chunk_of(input word_t w, input int k);
    chunk_t c;
    logic [BW-1:0] lw;
    for (int l = 0; l < VEC_LEN; l++) begin
      lw   = w[l] >> (k * W);
      c[l] = lw[W-1:0];
    end
    return c;
  endfunction

  task automatic drive_chunk(input chunk_t c);
    bus.vld_in = 1'b1;
    bus.in     = c;
    @(posedge clock);
    #1;
    exp_cnt = (exp_cnt + 1) % CYCS;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.vld_in = 1'b0;
      for (int l = 0; l < VEC_LEN; l++) bus.in[l] = W'($urandom);
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_word(input word_t w, input int gap_max);
    for (int k = 0; k < CYCS; k++) begin
      drive_chunk(chunk_of(w, k));
      if (k < CYCS - 1 && gap_max > 0) idle($urandom_range(0, gap_max));
    end
    exp_q.push_back(w);
    words_sent++;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  word_t w;
  int    n0;

  initial begin
    reset_n    = 1'b0;
    bus.vld_in = 1'b0;
    bus.in     = '0;
    #2;
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_vld", 64'(bus.vld_out), 64'd0);
    check("reset_out", 64'(bus.out), 64'd0);
    @(negedge clock);
    #1;
    reset_n = 1'b1;

    // Single word, then back-to-back pair.
    w[0] = 16'hA5C3; w[1] = 16'h1234;
    send_word(w, 0);
    idle(2);
    n0 = pulse_cyc.size();
    w[0] = 16'hA5C3; w[1] = 16'h1234;
    send_word(w, 0);
    w[0] = 16'hFFFF; w[1] = 16'h0001;
    send_word(w, 0);
    idle(2);
    check("b2b_pulses", 64'(pulse_cyc.size() - n0), 64'd2);
    if (pulse_cyc.size() == n0 + 2)
      check("b2b_spacing", 64'(pulse_cyc[n0+1] - pulse_cyc[n0]), 64'(CYCS));

    // Gapped word: three idle cycles in the middle.
    w[0] = 16'hA5C3; w[1] = 16'h5A5A;
    drive_chunk(chunk_of(w, 0));
    drive_chunk(chunk_of(w, 1));
    idle(3);
    drive_chunk(chunk_of(w, 2));
    drive_chunk(chunk_of(w, 3));
    exp_q.push_back(w);
    words_sent++;
    idle(2);

    // Asynchronous reset in the middle of a word.
    w[0] = 16'h9999; w[1] = 16'h7777;
    drive_chunk(chunk_of(w, 0));
    drive_chunk(chunk_of(w, 1));
    bus.vld_in = 1'b0;
    #1;
    reset_n = 1'b0;
    exp_cnt = 0;
    rst_count++;
    #1;
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_vld", 64'(bus.vld_out), 64'd0);
    check("midrst_out", 64'(bus.out), 64'd0);
    #1;
    reset_n = 1'b1;
    w[0] = 16'h4321; w[1] = 16'hBEEF;
    send_word(w, 0);

    // Idle hold with random data on the chunk inputs.
    idle(20);
    check("idle_busy", 64'(bus.busy), 64'd0);
    check("idle_out", 64'(bus.out), 64'(w));

    // Random regression.
    for (int n = 0; n < 200; n++) begin
      for (int l = 0; l < VEC_LEN; l++) w[l] = BW'($urandom);
      send_word(w, ($urandom_range(0, 1) == 1) ? 3 : 0);
      idle($urandom_range(0, 2));
    end
    idle(3);
    check("pending_words", 64'(exp_q.size()), 64'd0);
    check("pulse_count", 64'(pulses), 64'(words_sent));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
